// File: rtl/led_cmd_sequencer.sv
// SPI command decoder, pixel-write queue and frame-RAM arbiter for a
// double-buffered LED matrix: scanner reads share the RAM port with queued writes.
module led_cmd_sequencer #(
  parameter int STARVE_MAX = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  input  logic        i_rd_req,
  input  logic [9:0]  i_rd_addr,
  input  logic        i_frame_sync,
  output logic [10:0] o_ram_addr,
  output logic        o_ram_we,
  output logic [23:0] o_ram_wdata,
  output logic        o_rd_ack,
  output logic        o_bank,
  output logic        o_enable,
  output logic [7:0]  o_bright,
  output logic        o_overflow
);

  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } arb_state_t;

  arb_state_t state, state_next;

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [9:0]          wptr;
  logic                swap_pending;
  logic [34:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_idx, rd_idx;
  logic [CNT_W-1:0]    fifo_count;
  logic [STARVE_W-1:0] starve_cnt;
  logic                fifo_empty, fifo_full, starved;
  logic                cmd_set_addr, cmd_write, cmd_control;
  logic                push, pop, rd_grant, wr_grant;
  logic [34:0]         fifo_head;
  logic                unused_data_bits;

  // Release of reset is resynchronised so nothing is granted until two edges after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign cmd_set_addr = i_valid && (i_data[31:30] == 2'b01);
  assign cmd_write    = i_valid && (i_data[31:30] == 2'b10);
  assign cmd_control  = i_valid && (i_data[31:30] == 2'b11);

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign starved    = (starve_cnt >= STARVE_W'(STARVE_MAX));
  assign fifo_head  = fifo_mem[rd_idx];
  assign pop        = wr_grant;
  assign push       = cmd_write && (!fifo_full || pop);
  assign unused_data_bits = ^i_data[29:24];

  always_comb begin
    state_next = state;
    rd_grant   = 1'b0;
    wr_grant   = 1'b0;
    case (state)
      IDLE: begin
        if (i_rd_req && !starved) begin
          state_next = RD;
          rd_grant   = 1'b1;
        end else if (!fifo_empty) begin
          state_next = WR;
          wr_grant   = 1'b1;
        end
      end
      RD:      state_next = IDLE;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // RAM-side outputs are registered copies of the grant decision; address and data hold between grants.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_ack    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
    end else begin
      o_rd_ack <= rd_grant;
      o_ram_we <= wr_grant;
      if (rd_grant) begin
        o_ram_addr <= {o_bank, i_rd_addr};
      end else if (wr_grant) begin
        o_ram_addr  <= fifo_head[34:24];
        o_ram_wdata <= fifo_head[23:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_idx] <= {~o_bank, wptr, i_data[23:0]};
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + PTR_W'(1);
      if (pop)  rd_idx <= rd_idx + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (wr_grant || fifo_empty) starve_cnt <= '0;
      else if (!starved)          starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // A new swap request in the same cycle as a completed swap leaves the flag set.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      o_bright     <= 8'h80;
      o_enable     <= 1'b0;
      o_overflow   <= 1'b0;
      o_bank       <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (cmd_set_addr) wptr <= i_data[9:0];
      if (push)         wptr <= wptr + 10'd1;
      if (cmd_write && !push) o_overflow <= 1'b1;
      if (i_frame_sync && swap_pending && fifo_empty) begin
        o_bank       <= ~o_bank;
        swap_pending <= 1'b0;
      end
      if (cmd_control) begin
        o_bright <= i_data[7:0];
        o_enable <= i_data[8];
        if (i_data[9])  swap_pending <= 1'b1;
        if (i_data[10]) o_overflow   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Directed bench for led_cmd_sequencer: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_led_cmd_sequencer;

  localparam int STARVE_MAX = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_data;
  logic        i_valid;
  logic        i_rd_req;
  logic [9:0]  i_rd_addr;
  logic        i_frame_sync;
  logic [10:0] o_ram_addr;
  logic        o_ram_we;
  logic [23:0] o_ram_wdata;
  logic        o_rd_ack;
  logic        o_bank;
  logic        o_enable;
  logic [7:0]  o_bright;
  logic        o_overflow;

  int n_checks = 0;
  int n_fails  = 0;

  logic [10:0] wr_addr_q[$];
  logic [23:0] wr_data_q[$];

  led_cmd_sequencer #(.STARVE_MAX(STARVE_MAX), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_frame_sync(i_frame_sync),
    .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we), .o_ram_wdata(o_ram_wdata),
    .o_rd_ack(o_rd_ack), .o_bank(o_bank), .o_enable(o_enable),
    .o_bright(o_bright), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Record every RAM write seen on the falling edge.
  always @(negedge i_clk) begin
    if (o_ram_we === 1'b1) begin
      wr_addr_q.push_back(o_ram_addr);
      wr_data_q.push_back(o_ram_wdata);
    end
  end

  task automatic send_cmd(input logic [31:0] w);
    i_data  = w;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_data  = '0;
  endtask

  task automatic pulse_frame_sync();
    i_frame_sync = 1'b1;
    @(negedge i_clk);
    i_frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    int got;
    i_rd_req  = 1'b1;
    i_rd_addr = 10'h155;
    i_rst_n   = 1'b1;
    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    n_checks++; if (o_bank !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_bank: got %0b expected 0", o_bank); end
    n_checks++; if (o_enable !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_enable: got %0b expected 0", o_enable); end
    n_checks++; if (o_bright !== 8'h80) begin n_fails++; $display("[TB] FAIL reset_bright: got %h expected 80", o_bright); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_overflow: got %0b expected 0", o_overflow); end
    n_checks++; if (o_ram_we !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_we: got %0b expected 0", o_ram_we); end
    n_checks++; if (o_rd_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ack: got %0b expected 0", o_rd_ack); end
    n_checks++; if (o_ram_addr !== 11'h000) begin n_fails++; $display("[TB] FAIL reset_addr: got %h expected 000", o_ram_addr); end
    n_checks++; if (o_ram_wdata !== 24'h000000) begin n_fails++; $display("[TB] FAIL reset_wdata: got %h expected 000000", o_ram_wdata); end
    i_rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_rd_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL early_grant: cycle %0d got %0b expected 0", i + 1, o_rd_ack); end
    end
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      if (o_rd_ack === 1'b1) begin got = 1; break; end
    end
    n_checks++;
    if (got != 1) begin n_fails++; $display("[TB] FAIL first_grant: got no ack expected ack within 8 cycles"); end
    i_rd_req = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_write_wrap();
    logic [10:0] exp_addr [2];
    logic [23:0] exp_data [2];
    logic [10:0] a;
    logic [23:0] d;
    exp_addr[0] = 11'h7FF; exp_data[0] = 24'hFF0000;
    exp_addr[1] = 11'h400; exp_data[1] = 24'h00FF00;
    wr_addr_q.delete(); wr_data_q.delete();
    send_cmd(32'h4000_03FF);
    send_cmd(32'h80FF_0000);
    send_cmd(32'h8000_FF00);
    repeat (8) @(negedge i_clk);
    n_checks++;
    if (wr_addr_q.size() != 2) begin n_fails++; $display("[TB] FAIL wrap_count: got %0d writes expected 2", wr_addr_q.size()); end
    for (int i = 0; i < 2; i++) begin
      a = (i < wr_addr_q.size()) ? wr_addr_q[i] : 11'hxxx;
      d = (i < wr_data_q.size()) ? wr_data_q[i] : 24'hxxxxxx;
      n_checks++;
      if (a !== exp_addr[i]) begin n_fails++; $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, a, exp_addr[i]); end
      n_checks++;
      if (d !== exp_data[i]) begin n_fails++; $display("[TB] FAIL wrap_data%0d: got %h expected %h", i, d, exp_data[i]); end
    end
  endtask

  task automatic test_starve();
    logic prev;
    int   found;
    i_rd_addr = 10'h155;
    i_rd_req  = 1'b1;
    repeat (2) @(negedge i_clk);
    prev = o_rd_ack;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_rd_ack === prev) begin n_fails++; $display("[TB] FAIL ack_alternate: cycle %0d got %0b expected %0b", i, o_rd_ack, ~prev); end
      if (o_rd_ack === 1'b1) begin
        n_checks++;
        if (o_ram_addr !== 11'h155) begin n_fails++; $display("[TB] FAIL rd_addr: got %h expected 155", o_ram_addr); end
      end
      prev = o_rd_ack;
    end
    send_cmd(32'h80AB_CDEF);
    found = 0;
    for (int i = 1; i <= STARVE_MAX + 2; i++) begin
      @(negedge i_clk);
      if (o_ram_we === 1'b1) begin found = i; break; end
    end
    n_checks++;
    if (found == 0) begin n_fails++; $display("[TB] FAIL starve_write: got no write expected within %0d cycles", STARVE_MAX + 2); end
    n_checks++;
    if (o_ram_addr !== 11'h401) begin n_fails++; $display("[TB] FAIL starve_addr: got %h expected 401", o_ram_addr); end
    n_checks++;
    if (o_ram_wdata !== 24'hABCDEF) begin n_fails++; $display("[TB] FAIL starve_data: got %h expected abcdef", o_ram_wdata); end
    i_rd_req = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_overflow();
    logic [10:0] a;
    logic [23:0] d;
    wr_addr_q.delete(); wr_data_q.delete();
    i_rd_req = 1'b1;
    @(negedge i_clk);
    send_cmd(32'h4000_0100);
    for (int k = 1; k <= 5; k++) send_cmd(32'h8000_0000 | 32'(k));
    n_checks++;
    if (o_overflow !== 1'b1) begin n_fails++; $display("[TB] FAIL overflow_set: got %0b expected 1", o_overflow); end
    n_checks++;
    if (wr_addr_q.size() != 0) begin n_fails++; $display("[TB] FAIL overflow_held: got %0d writes expected 0", wr_addr_q.size()); end
    i_rd_req = 1'b0;
    repeat (12) @(negedge i_clk);
    n_checks++;
    if (wr_addr_q.size() != 4) begin n_fails++; $display("[TB] FAIL overflow_count: got %0d writes expected 4", wr_addr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < wr_addr_q.size()) ? wr_addr_q[i] : 11'hxxx;
      d = (i < wr_data_q.size()) ? wr_data_q[i] : 24'hxxxxxx;
      n_checks++;
      if (a !== 11'h500 + 11'(i)) begin n_fails++; $display("[TB] FAIL overflow_addr%0d: got %h expected %h", i, a, 11'h500 + 11'(i)); end
      n_checks++;
      if (d !== 24'(i + 1)) begin n_fails++; $display("[TB] FAIL overflow_data%0d: got %h expected %h", i, d, 24'(i + 1)); end
    end
    send_cmd(32'h8000_0006);
    repeat (4) @(negedge i_clk);
    a = (wr_addr_q.size() > 4) ? wr_addr_q[4] : 11'hxxx;
    n_checks++;
    if (a !== 11'h504) begin n_fails++; $display("[TB] FAIL dropped_wptr: got %h expected 504", a); end
    n_checks++;
    if (o_overflow !== 1'b1) begin n_fails++; $display("[TB] FAIL overflow_sticky: got %0b expected 1", o_overflow); end
    send_cmd(32'hC000_0480);
    n_checks++;
    if (o_overflow !== 1'b0) begin n_fails++; $display("[TB] FAIL overflow_clear: got %0b expected 0", o_overflow); end
    n_checks++;
    if (o_bright !== 8'h80) begin n_fails++; $display("[TB] FAIL ctrl_bright80: got %h expected 80", o_bright); end
  endtask

  task automatic test_bank_swap();
    pulse_frame_sync();
    n_checks++;
    if (o_bank !== 1'b0) begin n_fails++; $display("[TB] FAIL swap_unrequested: got %0b expected 0", o_bank); end
    send_cmd(32'hC000_0340);
    n_checks++;
    if (o_bright !== 8'h40) begin n_fails++; $display("[TB] FAIL ctrl_bright: got %h expected 40", o_bright); end
    n_checks++;
    if (o_enable !== 1'b1) begin n_fails++; $display("[TB] FAIL ctrl_enable: got %0b expected 1", o_enable); end
    n_checks++;
    if (o_bank !== 1'b0) begin n_fails++; $display("[TB] FAIL swap_early: got %0b expected 0", o_bank); end
    pulse_frame_sync();
    n_checks++;
    if (o_bank !== 1'b1) begin n_fails++; $display("[TB] FAIL swap_done: got %0b expected 1", o_bank); end
    pulse_frame_sync();
    n_checks++;
    if (o_bank !== 1'b1) begin n_fails++; $display("[TB] FAIL swap_once: got %0b expected 1", o_bank); end
  endtask

  task automatic test_swap_defer();
    logic [10:0] a;
    wr_addr_q.delete(); wr_data_q.delete();
    i_rd_req = 1'b1;
    @(negedge i_clk);
    send_cmd(32'hC000_0240);
    send_cmd(32'h8011_1111);
    send_cmd(32'h8022_2222);
    pulse_frame_sync();
    n_checks++;
    if (o_bank !== 1'b1) begin n_fails++; $display("[TB] FAIL defer_hold: got %0b expected 1", o_bank); end
    i_rd_req = 1'b0;
    repeat (10) @(negedge i_clk);
    n_checks++;
    if (wr_addr_q.size() != 2) begin n_fails++; $display("[TB] FAIL defer_count: got %0d writes expected 2", wr_addr_q.size()); end
    a = (wr_addr_q.size() > 1) ? wr_addr_q[1] : 11'hxxx;
    n_checks++;
    if (a !== 11'h106) begin n_fails++; $display("[TB] FAIL defer_addr: got %h expected 106", a); end
    n_checks++;
    if (o_bank !== 1'b1) begin n_fails++; $display("[TB] FAIL defer_still: got %0b expected 1", o_bank); end
    pulse_frame_sync();
    n_checks++;
    if (o_bank !== 1'b0) begin n_fails++; $display("[TB] FAIL defer_swap: got %0b expected 0", o_bank); end
  endtask

  task automatic test_reset_mid_wr();
    i_rd_req = 1'b0;
    send_cmd(32'h80AA_0001);
    send_cmd(32'h80AA_0002);
    send_cmd(32'h80AA_0003);
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_ram_we !== 1'b1) begin n_fails++; $display("[TB] FAIL midwr_active: got %0b expected 1", o_ram_we); end
    #1 i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_ram_we !== 1'b0) begin n_fails++; $display("[TB] FAIL midwr_we: got %0b expected 0", o_ram_we); end
    n_checks++; if (o_rd_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL midwr_ack: got %0b expected 0", o_rd_ack); end
    n_checks++; if (o_ram_addr !== 11'h000) begin n_fails++; $display("[TB] FAIL midwr_addr: got %h expected 000", o_ram_addr); end
    n_checks++; if (o_ram_wdata !== 24'h000000) begin n_fails++; $display("[TB] FAIL midwr_wdata: got %h expected 000000", o_ram_wdata); end
    n_checks++; if (o_bright !== 8'h80) begin n_fails++; $display("[TB] FAIL midwr_bright: got %h expected 80", o_bright); end
    n_checks++; if (o_bank !== 1'b0) begin n_fails++; $display("[TB] FAIL midwr_bank: got %0b expected 0", o_bank); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wr_addr_q.delete(); wr_data_q.delete();
    repeat (10) @(negedge i_clk);
    n_checks++;
    if (wr_addr_q.size() != 0) begin n_fails++; $display("[TB] FAIL midwr_fifo_empty: got %0d writes expected 0", wr_addr_q.size()); end
  endtask

  initial begin
    i_data       = '0;
    i_valid      = 1'b0;
    i_rd_req     = 1'b0;
    i_rd_addr    = '0;
    i_frame_sync = 1'b0;
    test_reset();
    test_write_wrap();
    test_starve();
    test_overflow();
    test_bank_swap();
    test_swap_defer();
    test_reset_mid_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
